// File: rtl/dma_seg_mmap_pkg.sv
// rtl/dma_seg_mmap_pkg.sv - register offsets, INFO magic and run-state type for the segmented DMA map
package dma_seg_mmap_pkg;

    localparam logic [15:0] REG_CTRL   = 16'h0000;
    localparam logic [15:0] REG_SIZE   = 16'h0002;
    localparam logic [15:0] REG_COUNT  = 16'h0004;
    localparam logic [15:0] REG_INFO   = 16'h0006;
    localparam logic [15:0] REG_SEG0   = 16'h0008;

    localparam logic [15:0] INFO_MAGIC = 16'hD5E6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } run_state_e;

endpackage

// File: rtl/mmio_if.sv
// rtl/mmio_if.sv - 64-bit MMIO word-addressed register port
interface mmio_if;

    logic        rd_en;
    logic [15:0] rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;

    modport user (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/dma_seg_run_ctrl.sv
// rtl/dma_seg_run_ctrl.sv - IDLE/BUSY run FSM with go pulse, sticky done and completion counter
module dma_seg_run_ctrl
    import dma_seg_mmap_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go_req,
    input  logic                 cnt_clr,
    input  logic                 done,
    output logic                 go,
    output logic                 busy,
    output logic                 done_sticky,
    output logic [CNT_WIDTH-1:0] count
);

    run_state_e           state_q, state_d;
    logic                 go_q, go_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        state_d  = state_q;
        go_d     = 1'b0;
        sticky_d = sticky_q;
        count_d  = count_q;
        if (state_q == IDLE) begin
            if (go_req) begin
                state_d  = BUSY;
                go_d     = 1'b1;
                sticky_d = 1'b0;
            end
        end else begin
            // A go request seen while busy is simply dropped.
            if (done) begin
                state_d  = IDLE;
                sticky_d = 1'b1;
                count_d  = count_q + 1'b1;
            end
        end
        if (cnt_clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            go_q     <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            go_q     <= go_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign go          = go_q;
    assign busy        = (state_q == BUSY);
    assign done_sticky = sticky_q;
    assign count       = count_q;

endmodule

// File: rtl/dma_seg_memory_map.sv
// rtl/dma_seg_memory_map.sv - MMIO register file for the segmented DMA loopback AFU
module dma_seg_memory_map
    import dma_seg_mmap_pkg::*;
#(
    parameter int          ADDR_WIDTH = 64,
    parameter int          SIZE_WIDTH = 32,
    parameter int          NUM_SEGS   = 4,
    parameter logic [15:0] BASE_ADDR  = 16'h0050,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    mmio_if.user                                 mmio,
    output logic [NUM_SEGS-1:0][ADDR_WIDTH-1:0]  wr_addr,
    output logic [SIZE_WIDTH-1:0]                size,
    output logic                                 go,
    input  logic                                 done
);

    localparam logic [15:0] A_CTRL  = BASE_ADDR + REG_CTRL;
    localparam logic [15:0] A_SIZE  = BASE_ADDR + REG_SIZE;
    localparam logic [15:0] A_COUNT = BASE_ADDR + REG_COUNT;
    localparam logic [15:0] A_INFO  = BASE_ADDR + REG_INFO;

    logic                                busy;
    logic                                done_sticky;
    logic [CNT_WIDTH-1:0]                count;
    logic [SIZE_WIDTH-1:0]               size_q, size_d;
    logic [NUM_SEGS-1:0][ADDR_WIDTH-1:0] seg_q, seg_d;
    logic [63:0]                         rd_data_q, rd_data_d;
    logic [63:0]                         rd_val;
    logic [NUM_SEGS-1:0]                 seg_wr_hit;
    logic [NUM_SEGS-1:0][63:0]           seg_rd_val;
    logic                                unused_wr_data;

    assign unused_wr_data = ^mmio.wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEGS; gi++) begin : g_seg_dec
            localparam logic [15:0] A_SEG = 16'(BASE_ADDR + REG_SEG0 + 16'(2 * gi));
            assign seg_wr_hit[gi] = mmio.wr_en && (mmio.wr_addr == A_SEG);
            assign seg_rd_val[gi] = (mmio.rd_addr == A_SEG) ? 64'(seg_q[gi]) : 64'd0;
        end
    endgenerate

    dma_seg_run_ctrl #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_run_ctrl (
        .clk         (clk),
        .rst         (rst),
        .go_req      (mmio.wr_en && (mmio.wr_addr == A_CTRL) && mmio.wr_data[0]),
        .cnt_clr     (mmio.wr_en && (mmio.wr_addr == A_COUNT)),
        .done        (done),
        .go          (go),
        .busy        (busy),
        .done_sticky (done_sticky),
        .count       (count)
    );

    // Configuration is frozen for the duration of a transfer.
    always_comb begin
        size_d = size_q;
        seg_d  = seg_q;
        if (!busy && mmio.wr_en && (mmio.wr_addr == A_SIZE)) begin
            size_d = mmio.wr_data[SIZE_WIDTH-1:0];
        end
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (!busy && seg_wr_hit[i]) begin
                seg_d[i] = mmio.wr_data[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_val = 64'd0;
        if (mmio.rd_addr == A_CTRL) begin
            rd_val = {62'd0, busy, done_sticky};
        end else if (mmio.rd_addr == A_SIZE) begin
            rd_val = 64'(size_q);
        end else if (mmio.rd_addr == A_COUNT) begin
            rd_val = 64'(count);
        end else if (mmio.rd_addr == A_INFO) begin
            rd_val = {32'd0, 16'(NUM_SEGS), INFO_MAGIC};
        end
        for (int i = 0; i < NUM_SEGS; i++) begin
            rd_val = rd_val | seg_rd_val[i];
        end
        rd_data_d = mmio.rd_en ? rd_val : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q    <= '0;
            seg_q     <= '0;
            rd_data_q <= '0;
        end else begin
            size_q    <= size_d;
            seg_q     <= seg_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign mmio.rd_data = rd_data_q;
    assign wr_addr      = seg_q;
    assign size         = size_q;

endmodule

// File: tb/tb_dma_seg_memory_map.sv
// tb/tb_dma_seg_memory_map.sv - directed table-driven bench for dma_seg_memory_map
module tb_dma_seg_memory_map;

    localparam int NSEG = 4;
    localparam logic [15:0] B = 16'h0050;

    logic clk = 1'b0;
    logic rst;
    logic done;
    logic go;
    logic [31:0] size;
    logic [NSEG-1:0][63:0] wr_addr;

    mmio_if mmio_bus ();

    dma_seg_memory_map #(
        .ADDR_WIDTH (64),
        .SIZE_WIDTH (32),
        .NUM_SEGS   (NSEG),
        .BASE_ADDR  (B),
        .CNT_WIDTH  (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mmio    (mmio_bus),
        .wr_addr (wr_addr),
        .size    (size),
        .go      (go),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
        bit          chk_out;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    logic [63:0] rv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        mmio_bus.wr_en   = 1'b1;
        mmio_bus.wr_addr = a;
        mmio_bus.wr_data = d;
        tick();
        mmio_bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [63:0] d);
        mmio_bus.rd_en   = 1'b1;
        mmio_bus.rd_addr = a;
        tick();
        mmio_bus.rd_en   = 1'b0;
        d = mmio_bus.rd_data;
    endtask

    function automatic logic [63:0] out_val(input logic [15:0] a);
        if (a == B + 16'h2) return 64'(size);
        return wr_addr[(a - B - 16'h8) >> 1];
    endfunction

    function automatic vec_t mk(input bit w, input logic [15:0] a, input logic [63:0] d,
                                input logic [63:0] e, input bit o);
        vec_t v;
        v.is_wr = w; v.addr = a; v.wdata = d; v.exp = e; v.chk_out = o;
        return v;
    endfunction

    initial begin
        // Reset-state reads, including odd and unmapped addresses.
        vecs.push_back(mk(0, B + 16'h0, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'h1, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'h2, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'h4, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'h6, 0, 64'h0000_0000_0004_D5E6, 0));
        vecs.push_back(mk(0, B + 16'h8, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'hA, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'hC, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'hE, 0, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'h10, 0, 64'h0, 0));
        // Configuration writes with read-back and output check.
        vecs.push_back(mk(1, B + 16'h8, 64'h1000, 64'h1000, 1));
        vecs.push_back(mk(1, B + 16'hA, 64'h2000, 64'h2000, 1));
        vecs.push_back(mk(1, B + 16'hC, 64'h3000, 64'h3000, 1));
        vecs.push_back(mk(1, B + 16'hE, 64'h4000, 64'h4000, 1));
        vecs.push_back(mk(1, B + 16'h2, 64'hFFFF_FFFF_1234_5678, 64'h1234_5678, 1));
        vecs.push_back(mk(1, B + 16'h2, 64'h40, 64'h40, 1));
        vecs.push_back(mk(1, B + 16'h6, 64'hFFFF, 64'h0000_0000_0004_D5E6, 0));
        vecs.push_back(mk(1, B + 16'h3, 64'h77, 64'h0, 0));
        vecs.push_back(mk(0, B + 16'h2, 0, 64'h40, 0));

        rst = 1'b1; done = 1'b0;
        mmio_bus.rd_en = 1'b0; mmio_bus.rd_addr = '0;
        mmio_bus.wr_en = 1'b0; mmio_bus.wr_addr = '0; mmio_bus.wr_data = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_go", 64'(go), 64'h0);
        check("reset_size", 64'(size), 64'h0);

        foreach (vecs[k]) begin
            if (vecs[k].is_wr) begin
                wr(vecs[k].addr, vecs[k].wdata);
                if (vecs[k].chk_out)
                    check($sformatf("out_%0d", k), out_val(vecs[k].addr), vecs[k].exp);
            end
            rd(vecs[k].addr, rv);
            check($sformatf("vec_%0d", k), rv, vecs[k].exp);
        end

        // Same-cycle read and write of SIZE returns the old value.
        mmio_bus.rd_en = 1'b1; mmio_bus.rd_addr = B + 16'h2;
        wr(B + 16'h2, 64'h41);
        mmio_bus.rd_en = 1'b0;
        check("rw_same_old", mmio_bus.rd_data, 64'h40);
        rd(B + 16'h2, rv);
        check("rw_same_new", rv, 64'h41);
        wr(B + 16'h2, 64'h40);

        // Go pulse and a held done counted once.
        wr(B, 64'h1);
        check("go_pulse", 64'(go), 64'h1);
        tick();
        check("go_single", 64'(go), 64'h0);
        rd(B, rv);
        check("ctrl_busy", rv, 64'h2);
        done = 1'b1; tick(); tick(); tick(); done = 1'b0;
        rd(B, rv);
        check("ctrl_done", rv, 64'h1);
        rd(B + 16'h4, rv);
        check("count_1", rv, 64'h1);

        // Write protection while busy.
        wr(B, 64'h1);
        check("go_pulse2", 64'(go), 64'h1);
        wr(B + 16'h2, 64'h99);
        wr(B + 16'h8, 64'hDEAD);
        wr(B, 64'h1);
        check("busy_no_go", 64'(go), 64'h0);
        check("busy_size_kept", 64'(size), 64'h40);
        check("busy_seg0_kept", wr_addr[0], 64'h1000);
        rd(B, rv);
        check("ctrl_busy2", rv, 64'h2);
        done = 1'b1; tick(); done = 1'b0;
        rd(B + 16'h4, rv);
        check("count_2", rv, 64'h2);

        // Go write coinciding with done while busy is dropped.
        wr(B, 64'h1);
        tick();
        done = 1'b1;
        wr(B, 64'h1);
        done = 1'b0;
        check("go_dropped", 64'(go), 64'h0);
        rd(B, rv);
        check("ctrl_idle_after", rv, 64'h1);
        rd(B + 16'h4, rv);
        check("count_3", rv, 64'h3);

        // COUNT clear beats a simultaneous increment.
        wr(B, 64'h1);
        tick();
        done = 1'b1;
        wr(B + 16'h4, 64'h0);
        done = 1'b0;
        rd(B + 16'h4, rv);
        check("count_clear_wins", rv, 64'h0);
        rd(B, rv);
        check("ctrl_after_clr", rv, 64'h1);

        // Reset in the middle of a transfer.
        wr(B, 64'h1);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_go", 64'(go), 64'h0);
        check("rst_size", 64'(size), 64'h0);
        check("rst_seg3", wr_addr[3], 64'h0);
        check("rst_rd_data", mmio_bus.rd_data, 64'h0);
        done = 1'b1; tick(); done = 1'b0;
        rd(B + 16'h4, rv);
        check("rst_count", rv, 64'h0);
        rd(B, rv);
        check("rst_ctrl", rv, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
